// File: rtl/biquad_band_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_band_scheduler
//  Description : Shares one signed 16x16 MAC across the low, mid and high
//                biquad bands. Each accepted sample runs 5 MAC steps plus a
//                write-back per band. All three band results are presented
//                together with a one-cycle out_valid pulse. Coefficients are
//                double-buffered. The shadow bank is written from the MCU side
//                and copied to the active bank only while the scheduler is idle.
//  Ports       : clk, reset (async, active-low)
//                sample_in/sample_valid/sample_ready : x[n] handshake
//                coef_we/coef_band/coef_sel/coef_wdata: shadow bank write
//                coef_commit/commit_pending           : shadow->active request
//                low_out/mid_out/high_out/out_valid   : band results
//  Revision    : 1.0 - initial release
// ============================================================================
module biquad_band_scheduler #(
    parameter int COEF_FRAC = 14,
    parameter int ACC_W     = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               coef_we,
    input  logic        [1:0]  coef_band,
    input  logic        [2:0]  coef_sel,
    input  logic signed [15:0] coef_wdata,
    input  logic               coef_commit,
    output logic               commit_pending,
    output logic signed [15:0] low_out,
    output logic signed [15:0] mid_out,
    output logic signed [15:0] high_out,
    output logic               out_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int                 C_NCOEF   = 15;
    localparam logic signed [15:0] C_UNITY   = 16'sd16384;
    localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = ACC_W'(-32768);

    logic        [1:0]       r_state;
    logic        [1:0]       r_band;
    logic        [2:0]       r_step;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [15:0]      r_x, r_x1, r_x2;
    logic signed [15:0]      r_y1  [0:2];
    logic signed [15:0]      r_y2  [0:2];
    logic signed [15:0]      r_res [0:2];
    logic signed [15:0]      r_shadow [0:C_NCOEF-1];
    logic signed [15:0]      r_active [0:C_NCOEF-1];

    // ------------------------------------------------------------------
    // Shadow write path. The copy uses the post-write shadow view, so a
    // write landing on the copy edge is included in the new active bank.
    // ------------------------------------------------------------------
    logic                    w_wr_ok;
    logic        [3:0]       w_wr_idx;
    logic signed [15:0]      w_shadow_next [0:C_NCOEF-1];
    logic                    w_apply;

    assign w_wr_ok  = coef_we && (coef_band != 2'd3) && (coef_sel < 3'd5);
    assign w_wr_idx = 4'(coef_band) * 4'd5 + 4'(coef_sel);
    assign w_apply  = (r_state == S_IDLE) && commit_pending;

    always_comb begin
        for (int i = 0; i < C_NCOEF; i++) w_shadow_next[i] = r_shadow[i];
        if (w_wr_ok) w_shadow_next[w_wr_idx] = coef_wdata;
    end

    // ------------------------------------------------------------------
    // MAC datapath: step 0..4 selects b0*x, b1*x1, b2*x2, a1*y1, a2*y2.
    // Feedback terms (steps 3 and 4) are subtracted.
    // ------------------------------------------------------------------
    logic        [3:0]       w_coef_idx;
    logic signed [15:0]      w_coef, w_data;
    logic signed [31:0]      w_coef_ext, w_data_ext, w_prod;
    logic signed [ACC_W-1:0] w_term, w_acc_base, w_acc_next, w_shr;
    logic signed [15:0]      w_y;

    assign w_coef_idx = 4'(r_band) * 4'd5 + 4'(r_step);
    assign w_coef     = r_active[w_coef_idx];

    always_comb begin
        case (r_step)
            3'd0:    w_data = r_x;
            3'd1:    w_data = r_x1;
            3'd2:    w_data = r_x2;
            3'd3:    w_data = r_y1[r_band];
            default: w_data = r_y2[r_band];
        endcase
    end

    assign w_coef_ext = 32'(w_coef);
    assign w_data_ext = 32'(w_data);
    assign w_prod     = w_coef_ext * w_data_ext;
    assign w_term     = ACC_W'(w_prod);
    assign w_acc_base = (r_step == 3'd0) ? '0 : r_acc;
    assign w_acc_next = (r_step >= 3'd3) ? (w_acc_base - w_term) : (w_acc_base + w_term);

    assign w_shr = r_acc >>> COEF_FRAC;
    assign w_y   = (w_shr > C_SAT_MAX) ? 16'sh7FFF :
                   (w_shr < C_SAT_MIN) ? 16'sh8000 : w_shr[15:0];

    // ------------------------------------------------------------------
    // Sequencer and state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_band         <= 2'd0;
            r_step         <= 3'd0;
            r_acc          <= '0;
            r_x            <= '0;
            r_x1           <= '0;
            r_x2           <= '0;
            sample_ready   <= 1'b0;
            commit_pending <= 1'b0;
            out_valid      <= 1'b0;
            low_out        <= '0;
            mid_out        <= '0;
            high_out       <= '0;
            for (int b = 0; b < 3; b++) begin
                r_y1[b]  <= '0;
                r_y2[b]  <= '0;
                r_res[b] <= '0;
            end
            for (int i = 0; i < C_NCOEF; i++) begin
                r_shadow[i] <= (i % 5 == 0) ? C_UNITY : 16'sd0;
                r_active[i] <= (i % 5 == 0) ? C_UNITY : 16'sd0;
            end
        end else begin
            out_valid <= 1'b0;

            for (int i = 0; i < C_NCOEF; i++) r_shadow[i] <= w_shadow_next[i];

            // A commit arriving on the copy edge is already satisfied.
            if (w_apply) begin
                for (int i = 0; i < C_NCOEF; i++) r_active[i] <= w_shadow_next[i];
                commit_pending <= 1'b0;
            end else if (coef_commit) begin
                commit_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    sample_ready <= 1'b1;
                    if (sample_valid && sample_ready) begin
                        r_x          <= sample_in;
                        sample_ready <= 1'b0;
                        r_band       <= 2'd0;
                        r_step       <= 3'd0;
                        r_state      <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_step == 3'd4) r_state <= S_WB;
                    else                r_step  <= r_step + 3'd1;
                end
                S_WB: begin
                    r_res[r_band] <= w_y;
                    r_y2[r_band]  <= r_y1[r_band];
                    r_y1[r_band]  <= w_y;
                    r_step        <= 3'd0;
                    if (r_band == 2'd2) begin
                        r_state <= S_DONE;
                    end else begin
                        r_band  <= r_band + 2'd1;
                        r_state <= S_MAC;
                    end
                end
                S_DONE: begin
                    low_out      <= r_res[0];
                    mid_out      <= r_res[1];
                    high_out     <= r_res[2];
                    out_valid    <= 1'b1;
                    sample_ready <= 1'b1;
                    r_x2         <= r_x1;
                    r_x1         <= r_x;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_biquad_band_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biquad_band_scheduler
//  Description : Scoreboard bench for biquad_band_scheduler. Accepted samples
//                are run through a plain-arithmetic biquad model and queued;
//                a monitor pops and compares on every out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_biquad_band_scheduler;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               sample_ready;
    logic               coef_we = 1'b0;
    logic        [1:0]  coef_band = '0;
    logic        [2:0]  coef_sel = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               coef_commit = 1'b0;
    logic               commit_pending;
    logic signed [15:0] low_out, mid_out, high_out;
    logic               out_valid;

    biquad_band_scheduler #(.COEF_FRAC(14), .ACC_W(40)) dut (
        .clk(clk), .reset(reset),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .coef_we(coef_we), .coef_band(coef_band), .coef_sel(coef_sel),
        .coef_wdata(coef_wdata), .coef_commit(coef_commit),
        .commit_pending(commit_pending),
        .low_out(low_out), .mid_out(mid_out), .high_out(high_out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct { longint lo; longint mi; longint hi; int acc_edge; } exp_t;
    exp_t   q[$];
    int     acc_edges[$];
    int     last_acc_edge = 0;
    longint m_shadow [15];
    longint m_active [15];
    longint m_x1, m_x2;
    longint m_y1 [3];
    longint m_y2 [3];
    bit     m_pending;
    int     m_pend_edge;
    int     e_next;
    bit     applied;

    function automatic longint sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 15; i++) begin
            m_shadow[i] = (i % 5 == 0) ? 16384 : 0;
            m_active[i] = m_shadow[i];
        end
        m_x1 = 0; m_x2 = 0;
        for (int b = 0; b < 3; b++) begin m_y1[b] = 0; m_y2[b] = 0; end
        m_pending = 0;
        q.delete();
        acc_edges.delete();
    endtask

    task automatic model_sample(input longint x, input int e);
        exp_t   r;
        longint y [3];
        for (int b = 0; b < 3; b++) begin
            longint acc;
            acc = m_active[b*5+0]*x + m_active[b*5+1]*m_x1 + m_active[b*5+2]*m_x2
                - m_active[b*5+3]*m_y1[b] - m_active[b*5+4]*m_y2[b];
            y[b]    = sat16(acc >>> 14);
            m_y2[b] = m_y1[b];
            m_y1[b] = y[b];
        end
        m_x2 = m_x1;
        m_x1 = x;
        r.lo = y[0]; r.mi = y[1]; r.hi = y[2]; r.acc_edge = e;
        q.push_back(r);
    endtask

    // Observe the bench's own drives just before each edge (e_next).
    always @(negedge clk) begin
        if (reset) begin
            e_next  = cyc + 1;
            applied = 0;
            if (coef_we && coef_band != 2'd3 && coef_sel < 3'd5)
                m_shadow[int'(coef_band)*5 + int'(coef_sel)] = coef_wdata;
            if (sample_valid && sample_ready) begin
                if (m_pending && m_pend_edge < e_next) begin
                    m_active  = m_shadow;
                    m_pending = 0;
                    applied   = 1;
                end
                model_sample(sample_in, e_next);
                acc_edges.push_back(e_next);
                last_acc_edge = e_next;
            end
            if (coef_commit && !m_pending && !applied) begin
                m_pending   = 1;
                m_pend_edge = e_next;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t r;
                r = q.pop_front();
                check("latency", cyc - r.acc_edge, 19);
                check("low_out", low_out, r.lo);
                check("mid_out", mid_out, r.mi);
                check("high_out", high_out, r.hi);
                check("ready_with_valid", sample_ready, 1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        sample_valid = 0; coef_we = 0; coef_commit = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_ready", sample_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pending", commit_pending, 0);
        check("rst_outs", {low_out, mid_out, high_out}, 0);
        reset = 1;
        @(negedge clk);
        check("ready_after_release", sample_ready, 1);
    endtask

    task automatic send(input logic signed [15:0] x);
        int n = 0;
        sample_in = x;
        sample_valid = 1;
        do begin @(negedge clk); n++; end while (!sample_ready && n < 200);
        if (!sample_ready) begin
            $display("FAIL handshake_timeout: got no ready expected ready within 200 cycles");
            $display("%0d/%0d checks passed", n_pass, n_checks + 1);
            $fatal(1, "handshake timeout");
        end
        @(posedge clk); #1;
        sample_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check("drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wr(input int band, input int sel, input int data, input bit commit);
        coef_we = 1; coef_band = 2'(band); coef_sel = 3'(sel);
        coef_wdata = 16'(data); coef_commit = commit;
        @(posedge clk); #1;
        coef_we = 0; coef_commit = 0;
    endtask

    task automatic pulse_commit();
        coef_commit = 1;
        @(posedge clk); #1;
        coef_commit = 0;
        repeat (2) @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int e;
        int nv;
        // 1: passthrough
        do_reset();
        send(16'sd1000);
        drain();

        // 2: low FIR tap b1 = 0.5
        do_reset();
        wr(0, 1, 8192, 0);
        pulse_commit();
        send(16'sd1000); send(16'sd0); send(16'sd0);
        drain();

        // 3: low feedback a1 = -0.5
        do_reset();
        wr(0, 3, -8192, 0);
        pulse_commit();
        send(16'sd1000); send(16'sd0); send(16'sd0);
        drain();

        // 4: saturation at both rails
        do_reset();
        for (int b = 0; b < 3; b++) wr(b, 0, 32767, 0);
        pulse_commit();
        send(16'sd32767); send(-16'sd32768);
        drain();

        // 5: commit mid-sample applies only to the next sample
        do_reset();
        send(16'sd1234);
        e = last_acc_edge;
        repeat (4) @(posedge clk); #1;
        wr(0, 0, 0, 1);
        @(negedge clk);
        check("pending_after_commit", commit_pending, 1);
        while (cyc < e + 19) @(negedge clk);
        check("pending_at_done", commit_pending, 1);
        @(negedge clk);
        check("pending_cleared_idle", commit_pending, 0);
        send(16'sd1234);
        drain();

        // 6: back-to-back handshakes, then reset mid-sample
        do_reset();
        for (int i = 0; i < 4; i++) send(16'(100 * (i + 1)));
        for (int i = 1; i < acc_edges.size(); i++)
            check("handshake_period", acc_edges[i] - acc_edges[i-1], 20);
        drain();
        send(16'sd777);
        e = last_acc_edge;
        while (cyc < e + 10) @(posedge clk);
        #1;
        reset = 0;
        model_clear();
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_outs", {low_out, mid_out, high_out}, 0);
        check("abort_ready", sample_ready, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("abort_ready_release", sample_ready, 1);
        nv = 0;
        repeat (25) begin @(negedge clk); if (out_valid) nv++; end
        check("abort_no_out_valid", nv, 0);

        // Random: coefficient bursts land while busy; illegal addresses mixed in.
        do_reset();
        for (int i = 0; i < 15; i++) wr(i / 5, i % 5, int'($urandom_range(0, 16383)) - 8192, 0);
        pulse_commit();
        for (int n = 0; n < 40; n++) begin
            logic signed [15:0] x;
            x = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 8000)) - 4000);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(x);
            if ($urandom_range(0, 2) == 0) begin
                int len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    int d = ($urandom_range(0, 4) == 0) ? int'(16'($urandom)) :
                            int'($urandom_range(0, 16383)) - 8192;
                    wr($urandom_range(0, 3), $urandom_range(0, 7), d,
                       (k == len - 1) && ($urandom_range(0, 1) == 1));
                end
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
